md_unit: RTL and testbench

//  Execute-stage multiply/divide unit with architectural HI/LO registers for the 5-stage

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_unit_if.sv | 20 ++
 rtl/md_calc.sv | 56 +++++
 rtl/md_unit.sv | 94 +++++++++
 tb/tb_md_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared opcodes, default latencies and FSM encoding for the multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  // Counter must hold latency-1 for the longer op, never narrower than 4 bits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_calc.sv
// Combinational MIPS mul/div arithmetic, including divide-by-zero and signed overflow.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic               ovf;
  logic [31:0]        sdiv_b;
  logic [31:0]        udiv_b;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign smul = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign umul = {32'b0, a_i} * {32'b0, b_i};

  assign div_zero_o = (b_i == 32'd0);
  assign ovf        = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Dividing by 1 on overflow yields exactly quotient=a, remainder=0.
  assign sdiv_b = (div_zero_o || ovf) ? 32'd1 : b_i;
  assign udiv_b = div_zero_o ? 32'd1 : b_i;

  assign sq = $signed(a_i) / $signed(sdiv_b);
  assign sr = $signed(a_i) % $signed(sdiv_b);
  assign uq = a_i / udiv_b;
  assign ur = a_i % udiv_b;

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (md_op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = smul;
      MD_MULTU: {res_hi_o, res_lo_o} = umul;
      MD_DIV: begin
        res_hi_o = sr;
        res_lo_o = sq;
      end
      MD_DIVU: begin
        res_hi_o = ur;
        res_lo_o = uq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: multi-cycle MULT/DIV with architectural HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int unsigned CntW = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CntW-1:0] MulInit = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivInit = CntW'(DIV_CYCLES - 1);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [31:0]     pend_hi_q;
  logic [31:0]     pend_lo_q;
  logic            pend_skip_q;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div_zero;
  logic        is_long;
  logic        is_div;

  md_calc u_calc (
    .md_op_i    (md.md_op),
    .a_i        (md.rs_val),
    .b_i        (md.rt_val),
    .res_hi_o   (calc_hi),
    .res_lo_o   (calc_lo),
    .div_zero_o (calc_div_zero)
  );

  assign is_div  = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);
  assign is_long = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU) || is_div;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_skip_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md.start) begin
            if (is_long) begin
              pend_hi_q   <= calc_hi;
              pend_lo_q   <= calc_lo;
              pend_skip_q <= is_div && calc_div_zero;
              cnt_q       <= is_div ? DivInit : MulInit;
              busy_q      <= 1'b1;
              state_q     <= ST_RUN;
            end else if (md.md_op == MD_MTHI) begin
              hi_q <= md.rs_val;
            end else if (md.md_op == MD_MTLO) begin
              lo_q <= md.rs_val;
            end
          end
        end
        ST_RUN: begin
          // Starts arriving here are ignored; D-stage stalls should prevent them.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!pend_skip_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a cycle-level reference model and literal spot checks.
module tb_md_unit;

  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  md_unit_if mif ();

  md_unit #(
    .MUL_CYCLES (MulN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic written directly from the ISA definitions using 64-bit math.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l, output bit skip);
    int sa;
    int sb;
    longint p;
    longint unsigned up;
    longint q;
    longint r;
    sa = a;
    sb = b;
    skip = 1'b0;
    h = 32'd0;
    l = 32'd0;
    case (op)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        {h, l} = p;
      end
      3'd1: begin
        up = 64'(a) * 64'(b);
        {h, l} = up;
      end
      3'd2: begin
        if (b == 32'd0) skip = 1'b1;
        else begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          l = q[31:0];
          h = r[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) skip = 1'b1;
        else begin
          l = a / b;
          h = a % b;
        end
      end
      default: skip = 1'b1;
    endcase
  endfunction

  // Model: an accepted long op completes exactly N edges later.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_busy, m_skip;
  longint      m_cyc, m_done;

  initial begin
    m_cyc = 0;
    m_busy = 1'b0;
  end

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_cyc == m_done) begin
        if (!m_skip) begin
          m_hi = m_ph;
          m_lo = m_pl;
        end
        m_busy = 1'b0;
      end
    end else if (mif.start) begin
      if (mif.md_op <= 3'd3) begin
        ref_calc(mif.md_op, mif.rs_val, mif.rt_val, m_ph, m_pl, m_skip);
        m_done = m_cyc + longint'((mif.md_op >= 3'd2) ? DivN : MulN);
        m_busy = 1'b1;
      end else if (mif.md_op == 3'd4) m_hi = mif.rs_val;
      else if (mif.md_op == 3'd5) m_lo = mif.rs_val;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, mif.busy}, {31'd0, m_busy});
      chk("model_hi", mif.hi, m_hi);
      chk("model_lo", mif.lo, m_lo);
    end
  end

  // Issue one op, then count cycles busy stays high (bounded); optionally inject
  // illegal starts while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse, output int cycles);
    mif.start  = 1'b1;
    mif.md_op  = op;
    mif.rs_val = a;
    mif.rt_val = b;
    @(negedge clk);
    mif.start = 1'b0;
    cycles = 0;
    while (mif.busy === 1'b1 && cycles < 64) begin
      mif.start = 1'b0;
      if (pulse && cycles == 3) begin
        mif.start  = 1'b1;
        mif.md_op  = 3'd4;
        mif.rs_val = 32'hDEAD_BEEF;
      end else if (pulse && cycles == 5) begin
        mif.start  = 1'b1;
        mif.md_op  = 3'd0;
        mif.rs_val = 32'd3;
        mif.rt_val = 32'd3;
      end
      cycles++;
      @(negedge clk);
    end
    mif.start = 1'b0;
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    mif.rs_val = 32'd0;
    mif.rt_val = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, mif.busy}, 32'd0);
    chk("reset_hi", mif.hi, 32'd0);
    chk("reset_lo", mif.lo, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc);
    chk("mult_cycles", 32'(cyc), 32'd5);
    chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mif.lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    chk("multu_cycles", 32'(cyc), 32'd5);
    chk("multu_hi", mif.hi, 32'hFFFF_FFFE);
    chk("multu_lo", mif.lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
    chk("div_cycles", 32'(cyc), 32'd10);
    chk("div_lo", mif.lo, 32'hFFFF_FFFD);
    chk("div_hi", mif.hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    chk("div_ovf_lo", mif.lo, 32'h8000_0000);
    chk("div_ovf_hi", mif.hi, 32'd0);

    run_op(3'd4, 32'h11, 32'd0, 1'b0, cyc);
    chk("mthi_cycles", 32'(cyc), 32'd0);
    run_op(3'd5, 32'h22, 32'd0, 1'b0, cyc);
    run_op(3'd3, 32'd5, 32'd0, 1'b0, cyc);
    chk("divu0_cycles", 32'(cyc), 32'd10);
    chk("divu0_hi", mif.hi, 32'h11);
    chk("divu0_lo", mif.lo, 32'h22);
    run_op(3'd4, 32'hABCD, 32'd0, 1'b0, cyc);
    chk("mthi_busy_cycles", 32'(cyc), 32'd0);
    chk("mthi_hi", mif.hi, 32'hABCD);

    run_op(3'd7, 32'h5555, 32'h3, 1'b0, cyc);
    chk("undef_cycles", 32'(cyc), 32'd0);
    chk("undef_hi", mif.hi, 32'hABCD);
    chk("undef_lo", mif.lo, 32'h22);

    // Abort a MULT in its second RUN cycle.
    mif.start = 1'b1;
    mif.md_op = 3'd0;
    mif.rs_val = 32'd7;
    mif.rt_val = 32'd9;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, mif.busy}, 32'd0);
    chk("abort_hi", mif.hi, 32'd0);
    chk("abort_lo", mif.lo, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_late_hi", mif.hi, 32'd0);
    chk("abort_late_lo", mif.lo, 32'd0);

    run_op(3'd0, 32'h1234, 32'h10, 1'b0, cyc);
    chk("b2b_mult_lo", mif.lo, 32'h0001_2340);
    run_op(3'd2, 32'hFFFF_FF9C, 32'd7, 1'b1, cyc);
    chk("b2b_div_cycles", 32'(cyc), 32'd10);
    chk("b2b_div_lo", mif.lo, 32'hFFFF_FFF2);
    chk("b2b_div_hi", mif.hi, 32'hFFFF_FFFE);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
